operand_collector_seq: RTL and testbench
========================================

# operand_collector_seq

Parametrised, single-clock successor to the lane operand collector. Per lane, it accepts one issued instruction and reads its predicate plus up to `NUM_SRC` source operands sequentially from a 1R1W register bank. It also arbitrates `NUM_WB` write-back ports into the bank's single write port, then presents the collected operands to the functional unit over a valid/ready handshake. It sits between the warp issue stage and the INTU/FPU/LSU lane datapaths.

## Interface
Parameters:
- `NUM_WARP`, 8: warps sharing the bank; `WARP_LOG = $clog2(NUM_WARP)`
- `REGS_PER_WARP`, 16: registers per warp; `REG_LOG = $clog2(REGS_PER_WARP)`
- `DATA_W`, 32: operand width
- `NUM_SRC`, 3: source operands per instruction, 1..4
- `NUM_WB`, 2: write-back ports, 1..4
- `PREDEF_W`, 16: width of each predefined special register

Ports (clock and reset first):
- `clk`, in, 1: sole clock
- `reset`, in, 1: synchronous, active-high
- `stall_i`, in, 1: freezes the FSM, the output register and bank writes
- `issue_valid_i` / `issue_ready_o`, in/out, 1: issue handshake
- `issue_warp_i`, in, `WARP_LOG`: warp of the issued instruction
- `issue_pred_i`, in, `REG_LOG`: predicate register index
- `issue_src_i`, in, `NUM_SRC*REG_LOG`: source indices; src0 occupies the LSBs
- `issue_sr_i`, in, 1: src0 names a special register
- `predef_i`, in, `12*PREDEF_W`: tid.xyz, ntid.xyz, ctaid.xyz, nctaid.xyz, with tid.x in the MSBs
- `wb_valid_i` / `wb_ready_o`, in/out, `NUM_WB`: per-port write-back handshake
- `wb_warp_i`, in, `NUM_WB*WARP_LOG`: write-back warp
- `wb_reg_i`, in, `NUM_WB*REG_LOG`: write-back register index
- `wb_data_i`, in, `NUM_WB*DATA_W`: write-back data
- `out_valid_o` / `out_ready_i`, out/in, 1: operand handshake to the FU
- `out_pred_o`, out, 1: bit 0 of the predicate register
- `out_data_o`, out, `NUM_SRC*DATA_W`: collected operands; src0 occupies the LSBs

## Operation
- FSM states: IDLE, READ, HOLD.
  - IDLE: `issue_ready_o`=1. Issue accepted (valid&&ready, no stall): latch warp/indices/sr, slot counter=0 → READ.
  - READ: presents bank address `{warp, idx}` for slot `k` (slot 0 = pred, slot k = src(k-1)); data captured next cycle. The last slot's capture → HOLD. When `issue_sr_i`=1, only slot 0 is read.
  - HOLD: `out_valid_o`=1; on `out_ready_i` → IDLE. Back-to-back issue is not accepted in the same cycle.
- Operand rules:
  - Register index 0 reads as 0 regardless of bank contents.
  - In SR mode, src0 = zero-extended predefined register selected by src0 index[3:0]: codes 1..12 map to tid.x..nctaid.z; other codes give 0. Remaining sources are 0.
- Write-back: each port has a one-entry holding register.
  - `wb_ready_o[p]` = holding register empty.
  - Round-robin arbiter commits one held entry per non-stalled cycle. Pointer advances past the winner.
  - Write to register 0 is committed but never observable.
- Bank is 1R1W, synchronous read, read-first on same-address collision.
- Ordering between a held write and a later read is the scoreboard's responsibility.

## Timing
- Reset values: state IDLE, `issue_ready_o`=1, `out_valid_o`=0, `out_pred_o`=0, `out_data_o`=0, `wb_ready_o`=all 1s, RR pointer=0. Bank contents are not reset.
- Latency, accept to `out_valid_o`: `NUM_SRC+2` cycles; SR mode: 2 cycles. Example: NUM_SRC=3 → 5.
- Write-back: a port whose entry is accepted in cycle t is committed no earlier than t+1 and no later than t+`NUM_WB`.
- `stall_i`: counter, captures, commits and the handshakes all freeze. `out_valid_o` and data are held stable.
- `reset` mid-READ or mid-HOLD: return to IDLE next cycle; held write-back entries are discarded.
- Simultaneous write-back and read, same address, same cycle: read returns old data, unless bypass is enabled.

## Configuration
- `OC_BYPASS_EN` defined: a read slot whose address equals the address committed in the same cycle captures the committed data.
- Undefined: read-first semantics; no forwarding mux.

## Structure
- Package `oc_pkg`: SR code constants (`SR_TID_X`=1 … `SR_NCTAID_Z`=12), FSM state enum, slot index type.
- Sub-module `oc_rr_arbiter`: parametrised `NUM_WB` round-robin grant with pointer register.
- Bank is an inferred 1R1W array inside the top module.

## Test plan
- Write r5 of w2 = 0xDEADBEEF via port 0. Issue w2 with src0=r5, src1=r0, src2=r5 → after 5 cycles, out_data = {0xDEADBEEF, 0, 0xDEADBEEF}.
- Issue with SR mode, src0 code 7, ctaid.x=0x0042 → after 2 cycles, src0=0x00000042, src1=src2=0.
- All `NUM_WB` ports valid in one cycle (w1 r1..r2) → each commits within 2 cycles; grant order alternates on a repeated burst.
- Hold `out_ready_i`=0 for 4 cycles, pulse `stall_i` mid-READ → outputs stable; latency extends by stall length.
- Write w3 r4=0x11 in the same cycle slot 1 reads w3 r4 → captures 0x11 with `OC_BYPASS_EN`, previous value without it.
- Assert `reset` in HOLD with a held write-back → next cycle IDLE, `out_valid_o`=0, `wb_ready_o` all 1s; the held write is not committed.

Source files
------------

// File: rtl/oc_pkg.sv
// Shared types and constants for the sequential operand collector:
// special-register codes, FSM state encoding and the read-slot index type.
package oc_pkg;

    localparam logic [3:0] SR_TID_X    = 4'd1;
    localparam logic [3:0] SR_TID_Y    = 4'd2;
    localparam logic [3:0] SR_TID_Z    = 4'd3;
    localparam logic [3:0] SR_NTID_X   = 4'd4;
    localparam logic [3:0] SR_NTID_Y   = 4'd5;
    localparam logic [3:0] SR_NTID_Z   = 4'd6;
    localparam logic [3:0] SR_CTAID_X  = 4'd7;
    localparam logic [3:0] SR_CTAID_Y  = 4'd8;
    localparam logic [3:0] SR_CTAID_Z  = 4'd9;
    localparam logic [3:0] SR_NCTAID_X = 4'd10;
    localparam logic [3:0] SR_NCTAID_Y = 4'd11;
    localparam logic [3:0] SR_NCTAID_Z = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } oc_state_e;

    // Slot 0 is the predicate, slots 1..NUM_SRC are the sources (NUM_SRC <= 4).
    typedef logic [2:0] slot_t;

endpackage

// File: rtl/oc_rr_arbiter.sv
// Round-robin grant among NUM_WB requesters; the pointer moves one past the
// winner whenever a grant is taken (en_i high).
module oc_rr_arbiter #(
    parameter int NUM_WB = 2,
    localparam int IDX_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [NUM_WB-1:0] req_i,
    output logic [NUM_WB-1:0] gnt_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              gnt_valid_o
);

    localparam int CW = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [CW-1:0]    sum_s;
    logic [CW-1:0]    cand_s;

    // Scan requesters starting at the pointer; the first one found wins.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        sum_s       = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            sum_s  = {1'b0, ptr_q} + CW'(i);
            cand_s = (sum_s >= CW'(NUM_WB)) ? (sum_s - CW'(NUM_WB)) : sum_s;
            if (!gnt_valid_o && req_i[cand_s[IDX_W-1:0]]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand_s[IDX_W-1:0];
            end else begin
                gnt_idx_o   = gnt_idx_o;
            end
        end
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

    // Pointer advance past the winner.
    always_comb begin
        if (en_i && gnt_valid_o) begin
            ptr_d = (gnt_idx_o == IDX_W'(NUM_WB - 1)) ? '0 : (gnt_idx_o + IDX_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/operand_collector_seq.sv
// Per-lane operand collector: sequential predicate/source reads from a 1R1W
// bank, round-robin write-back arbitration. Define OC_BYPASS_EN to forward
// same-cycle committed data to a colliding read slot.
module operand_collector_seq
    import oc_pkg::*;
#(
    parameter int NUM_WARP      = 8,
    parameter int REGS_PER_WARP = 16,
    parameter int DATA_W        = 32,
    parameter int NUM_SRC       = 3,
    parameter int NUM_WB        = 2,
    parameter int PREDEF_W      = 16,
    localparam int WARP_LOG     = $clog2(NUM_WARP),
    localparam int REG_LOG      = $clog2(REGS_PER_WARP)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [WARP_LOG-1:0]         issue_warp_i,
    input  logic [REG_LOG-1:0]          issue_pred_i,
    input  logic [NUM_SRC*REG_LOG-1:0]  issue_src_i,
    input  logic                        issue_sr_i,
    input  logic [12*PREDEF_W-1:0]      predef_i,
    input  logic [NUM_WB-1:0]           wb_valid_i,
    output logic [NUM_WB-1:0]           wb_ready_o,
    input  logic [NUM_WB*WARP_LOG-1:0]  wb_warp_i,
    input  logic [NUM_WB*REG_LOG-1:0]   wb_reg_i,
    input  logic [NUM_WB*DATA_W-1:0]    wb_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        out_pred_o,
    output logic [NUM_SRC*DATA_W-1:0]   out_data_o
);

    localparam int    ADDR_W    = WARP_LOG + REG_LOG;
    localparam int    IDX_W     = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
    localparam slot_t LAST_SLOT = slot_t'(NUM_SRC);

    oc_state_e                        state_q, state_d;
    slot_t                            slot_q, slot_d;
    logic [WARP_LOG-1:0]              warp_q, warp_d;
    logic [REG_LOG-1:0]               pred_idx_q, pred_idx_d;
    logic [NUM_SRC*REG_LOG-1:0]       src_q, src_d;
    logic                             sr_q, sr_d;
    logic                             out_pred_q, out_pred_d;
    logic [NUM_SRC*DATA_W-1:0]        out_data_q, out_data_d;

    logic [NUM_WB-1:0]                wb_held_q, wb_held_d;
    logic [NUM_WB-1:0][WARP_LOG-1:0]  wb_warp_q, wb_warp_d;
    logic [NUM_WB-1:0][REG_LOG-1:0]   wb_reg_q, wb_reg_d;
    logic [NUM_WB-1:0][DATA_W-1:0]    wb_data_q, wb_data_d;

    logic [DATA_W-1:0]                bank_mem [2**ADDR_W];

    logic [NUM_WB-1:0]                gnt_s;
    logic [IDX_W-1:0]                 gnt_idx_s;
    logic                             gnt_valid_s;
    logic                             commit_s;
    logic [ADDR_W-1:0]                wr_addr_s;
    logic [DATA_W-1:0]                wr_data_s;
    logic [REG_LOG-1:0]               rd_idx_s;
    logic [ADDR_W-1:0]                rd_addr_s;
    logic [DATA_W-1:0]                bank_rd_s;
    logic [DATA_W-1:0]                rd_operand_s;
    logic [DATA_W-1:0]                sr_operand_s;
    logic                             issue_fire_s;
    logic                             out_fire_s;

    // Zero-extended special register for codes 1..12 (tid.x sits in the MSBs).
    function automatic logic [DATA_W-1:0] sr_value(input logic [3:0]            code,
                                                   input logic [12*PREDEF_W-1:0] pd);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int c = 32'(SR_TID_X); c <= 32'(SR_NCTAID_Z); c++) begin
            val = (code == 4'(c)) ? DATA_W'(pd[(13 - c)*PREDEF_W - 1 -: PREDEF_W]) : val;
        end
        return val;
    endfunction

    assign issue_ready_o = (state_q == ST_IDLE) && !stall_i;
    assign issue_fire_s  = issue_valid_i && issue_ready_o;
    assign out_valid_o   = (state_q == ST_HOLD);
    assign out_fire_s    = out_valid_o && out_ready_i && !stall_i;
    assign out_pred_o    = out_pred_q;
    assign out_data_o    = out_data_q;
    assign wb_ready_o    = ~wb_held_q & {NUM_WB{~stall_i}};

    oc_rr_arbiter #(
        .NUM_WB (NUM_WB)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .en_i        (~stall_i),
        .req_i       (wb_held_q),
        .gnt_o       (gnt_s),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // A reset cycle never commits, so held entries are dropped rather than written.
    assign commit_s  = gnt_valid_s && !stall_i && !reset;
    assign wr_addr_s = {wb_warp_q[gnt_idx_s], wb_reg_q[gnt_idx_s]};
    assign wr_data_s = wb_data_q[gnt_idx_s];

    // Read address for the current slot and the operand it yields.
    always_comb begin
        rd_idx_s = pred_idx_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            rd_idx_s = (slot_q == slot_t'(k + 1)) ? src_q[k*REG_LOG +: REG_LOG] : rd_idx_s;
        end
        rd_addr_s = {warp_q, rd_idx_s};
`ifdef OC_BYPASS_EN
        bank_rd_s = (commit_s && (wr_addr_s == rd_addr_s)) ? wr_data_s : bank_mem[rd_addr_s];
`else
        bank_rd_s = bank_mem[rd_addr_s];
`endif
        rd_operand_s = (rd_idx_s == '0) ? '0 : bank_rd_s;
        sr_operand_s = sr_value(4'(src_q[REG_LOG-1:0]), predef_i);
    end

    // Collector FSM: next state, latched instruction and operand captures.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        warp_d     = warp_q;
        pred_idx_d = pred_idx_q;
        src_d      = src_q;
        sr_d       = sr_q;
        out_pred_d = out_pred_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_fire_s) begin
                    warp_d     = issue_warp_i;
                    pred_idx_d = issue_pred_i;
                    src_d      = issue_src_i;
                    sr_d       = issue_sr_i;
                    slot_d     = '0;
                    state_d    = ST_READ;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_READ: begin
                if (stall_i) begin
                    state_d = ST_READ;
                end else if (slot_q == '0) begin
                    out_pred_d = rd_operand_s[0];
                    if (sr_q) begin
                        out_data_d               = '0;
                        out_data_d[DATA_W-1:0]   = sr_operand_s;
                        state_d                  = ST_HOLD;
                    end else begin
                        slot_d  = slot_q + slot_t'(1);
                        state_d = ST_READ;
                    end
                end else begin
                    for (int k = 0; k < NUM_SRC; k++) begin
                        out_data_d[k*DATA_W +: DATA_W] = (slot_q == slot_t'(k + 1)) ?
                            rd_operand_s : out_data_q[k*DATA_W +: DATA_W];
                    end
                    if (slot_q == LAST_SLOT) begin
                        state_d = ST_HOLD;
                    end else begin
                        slot_d  = slot_q + slot_t'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_HOLD: begin
                if (out_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-back holding registers: fill on handshake, drain on commit.
    always_comb begin
        wb_held_d = wb_held_q;
        wb_warp_d = wb_warp_q;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p] && wb_ready_o[p]) begin
                wb_held_d[p] = 1'b1;
                wb_warp_d[p] = wb_warp_i[p*WARP_LOG +: WARP_LOG];
                wb_reg_d[p]  = wb_reg_i[p*REG_LOG +: REG_LOG];
                wb_data_d[p] = wb_data_i[p*DATA_W +: DATA_W];
            end else if (commit_s && gnt_s[p]) begin
                wb_held_d[p] = 1'b0;
            end else begin
                wb_held_d[p] = wb_held_q[p];
            end
        end
    end

    // State, capture and holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            warp_q     <= '0;
            pred_idx_q <= '0;
            src_q      <= '0;
            sr_q       <= 1'b0;
            out_pred_q <= 1'b0;
            out_data_q <= '0;
            wb_held_q  <= '0;
            wb_warp_q  <= '0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            warp_q     <= warp_d;
            pred_idx_q <= pred_idx_d;
            src_q      <= src_d;
            sr_q       <= sr_d;
            out_pred_q <= out_pred_d;
            out_data_q <= out_data_d;
            wb_held_q  <= wb_held_d;
            wb_warp_q  <= wb_warp_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Register bank write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            bank_mem[wr_addr_s] <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_operand_collector_seq.sv
// Scoreboard bench for operand_collector_seq: directed issues push expected
// operands and arrival cycle; a negedge monitor checks them while valid.
module tb_operand_collector_seq;

    localparam int NUM_SRC = 3;
    localparam int NUM_WB  = 2;
    localparam int DATA_W  = 32;
    localparam int PW      = 16;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       stall_i;
    logic                       issue_valid_i;
    logic                       issue_ready_o;
    logic [2:0]                 issue_warp_i;
    logic [3:0]                 issue_pred_i;
    logic [NUM_SRC*4-1:0]       issue_src_i;
    logic                       issue_sr_i;
    logic [12*PW-1:0]           predef_i;
    logic [NUM_WB-1:0]          wb_valid_i;
    logic [NUM_WB-1:0]          wb_ready_o;
    logic [NUM_WB*3-1:0]        wb_warp_i;
    logic [NUM_WB*4-1:0]        wb_reg_i;
    logic [NUM_WB*DATA_W-1:0]   wb_data_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic                       out_pred_o;
    logic [NUM_SRC*DATA_W-1:0]  out_data_o;

    typedef struct {
        logic [95:0] data;
        logic        pred;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic seen     = 1'b0;

    operand_collector_seq dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_warp_i  (issue_warp_i),
        .issue_pred_i  (issue_pred_i),
        .issue_src_i   (issue_src_i),
        .issue_sr_i    (issue_sr_i),
        .predef_i      (predef_i),
        .wb_valid_i    (wb_valid_i),
        .wb_ready_o    (wb_ready_o),
        .wb_warp_i     (wb_warp_i),
        .wb_reg_i      (wb_reg_i),
        .wb_data_i     (wb_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_pred_o    (out_pred_o),
        .out_data_o    (out_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on the first valid cycle, operands on every valid cycle.
    always @(negedge clk) begin
        if (!reset && out_valid_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got valid with empty scoreboard (cycle %0d)", cyc);
            end else begin
                if (!seen) check("latency", 96'(cyc), 96'(sb_q[0].cyc));
                check("out_data", out_data_o, sb_q[0].data);
                check("out_pred", 96'(out_pred_o), 96'(sb_q[0].pred));
                if (out_ready_i && !stall_i) void'(sb_q.pop_front());
            end
            seen <= !(out_ready_i && !stall_i);
        end else begin
            seen <= 1'b0;
        end
    end

    task automatic do_issue(input logic [2:0] w, input logic [3:0] p, input logic [11:0] s,
                            input logic sr, input logic [95:0] ed, input logic ep, input int lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(posedge clk); #1;
        issue_warp_i  = w;
        issue_pred_i  = p;
        issue_src_i   = s;
        issue_sr_i    = sr;
        issue_valid_i = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (issue_ready_o && !stall_i) begin
                e.data = ed;
                e.pred = ep;
                e.cyc  = cyc + lat;
                sb_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) check("issue_timeout", 96'(0), 96'(1));
        @(posedge clk); #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic set_wb(input int p, input logic [2:0] w, input logic [3:0] r, input logic [31:0] d);
        wb_warp_i[p*3 +: 3]           = w;
        wb_reg_i[p*4 +: 4]            = r;
        wb_data_i[p*DATA_W +: DATA_W] = d;
        wb_valid_i[p]                 = 1'b1;
    endtask

    task automatic wb_write(input int p, input logic [2:0] w, input logic [3:0] r, input logic [31:0] d);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        set_wb(p, w, r, d);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = wb_ready_o[p];
        end
        if (!done) check("wb_timeout", 96'(0), 96'(1));
        @(posedge clk); #1;
        wb_valid_i = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic burst(input logic [2:0] w, input logic [3:0] r0, input logic [31:0] d0,
                         input logic [3:0] r1, input logic [31:0] d1, input logic [1:0] first);
        @(posedge clk); #1;
        set_wb(0, w, r0, d0);
        set_wb(1, w, r1, d1);
        @(negedge clk);
        check("burst_accept", 96'(wb_ready_o), 96'(2'b11));
        @(posedge clk); #1;
        wb_valid_i = '0;
        @(negedge clk);
        check("burst_held", 96'(wb_ready_o), 96'(2'b00));
        @(negedge clk);
        check("burst_first", 96'(wb_ready_o), 96'(first));
        @(negedge clk);
        check("burst_done", 96'(wb_ready_o), 96'(2'b11));
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            check("drain_timeout", 96'(sb_q.size()), 96'(0));
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 30 && !out_valid_o; i++) @(negedge clk);
        if (!out_valid_o) check("valid_timeout", 96'(0), 96'(1));
    endtask

    initial begin
        logic [31:0] byp_exp;
        reset         = 1'b1;
        stall_i       = 1'b0;
        issue_valid_i = 1'b0;
        issue_warp_i  = '0;
        issue_pred_i  = '0;
        issue_src_i   = '0;
        issue_sr_i    = 1'b0;
        wb_valid_i    = '0;
        wb_warp_i     = '0;
        wb_reg_i      = '0;
        wb_data_i     = '0;
        out_ready_i   = 1'b1;
        predef_i      = '0;
        for (int c = 1; c <= 12; c++) predef_i[(13 - c)*PW - 1 -: PW] = 16'h1000 + 16'(c);
        predef_i[6*PW - 1 -: PW] = 16'h0042;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_issue_ready", 96'(issue_ready_o), 96'(1));
        check("rst_out_valid", 96'(out_valid_o), 96'(0));
        check("rst_out_pred", 96'(out_pred_o), 96'(0));
        check("rst_out_data", out_data_o, 96'(0));
        check("rst_wb_ready", 96'(wb_ready_o), 96'(2'b11));

        // w2 r5 = DEADBEEF; read {r5, r0, r5} with pred r5.
        wb_write(0, 3'd2, 4'd5, 32'hDEADBEEF);
        do_issue(3'd2, 4'd5, {4'd5, 4'd0, 4'd5}, 1'b0,
                 {32'hDEADBEEF, 32'h0, 32'hDEADBEEF}, 1'b1, 5);
        drain();

        // Pointer is 1 here: port 1 wins first; a single port-1 write flips the order.
        burst(3'd1, 4'd1, 32'h101, 4'd2, 32'h202, 2'b10);
        wb_write(1, 3'd1, 4'd3, 32'h303);
        burst(3'd1, 4'd1, 32'h111, 4'd2, 32'h222, 2'b01);
        do_issue(3'd1, 4'd3, {4'd3, 4'd2, 4'd1}, 1'b0,
                 {32'h303, 32'h222, 32'h111}, 1'b1, 5);
        drain();

        // Special-register mode.
        do_issue(3'd1, 4'd3, {4'd2, 4'd1, 4'd7}, 1'b1, {64'h0, 32'h42}, 1'b1, 2);
        drain();
        do_issue(3'd1, 4'd0, {4'd5, 4'd5, 4'd12}, 1'b1, {64'h0, 32'h100C}, 1'b0, 2);
        drain();
        do_issue(3'd1, 4'd0, {4'd5, 4'd5, 4'd13}, 1'b1, 96'h0, 1'b0, 2);
        drain();
        do_issue(3'd1, 4'd0, {4'd5, 4'd5, 4'd0}, 1'b1, 96'h0, 1'b0, 2);
        drain();

        // Two-cycle stall mid-READ, output back-pressure, stall during HOLD.
        out_ready_i = 1'b0;
        do_issue(3'd2, 4'd0, {4'd0, 4'd5, 4'd5}, 1'b0,
                 {32'h0, 32'hDEADBEEF, 32'hDEADBEEF}, 1'b0, 7);
        @(posedge clk); #1 stall_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 stall_i = 1'b0;
        wait_valid();
        repeat (4) @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        stall_i     = 1'b1;
        @(posedge clk); #1 stall_i = 1'b0;
        drain();

        // Commit collides with the src0 read of w3 r4.
        wb_write(0, 3'd3, 4'd4, 32'h77);
`ifdef OC_BYPASS_EN
        byp_exp = 32'h11;
`else
        byp_exp = 32'h77;
`endif
        do_issue(3'd3, 4'd0, {4'd0, 4'd4, 4'd4}, 1'b0, {32'h0, 32'h11, byp_exp}, 1'b0, 5);
        set_wb(0, 3'd3, 4'd4, 32'h11);
        @(posedge clk); #1 wb_valid_i = '0;
        drain();

        // Reset in HOLD with both write-back ports holding entries.
        burst(3'd5, 4'd6, 32'h600D, 4'd7, 32'h700D, 2'b10);
        out_ready_i = 1'b0;
        do_issue(3'd5, 4'd0, {4'd0, 4'd0, 4'd6}, 1'b0, {64'h0, 32'h600D}, 1'b0, 5);
        wait_valid();
        @(posedge clk); #1;
        set_wb(0, 3'd5, 4'd6, 32'hBAD6);
        set_wb(1, 3'd5, 4'd7, 32'hBAD7);
        @(posedge clk); #1;
        wb_valid_i = '0;
        reset      = 1'b1;
        sb_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_issue_ready", 96'(issue_ready_o), 96'(1));
        check("mid_rst_out_valid", 96'(out_valid_o), 96'(0));
        check("mid_rst_wb_ready", 96'(wb_ready_o), 96'(2'b11));
        check("mid_rst_out_data", out_data_o, 96'(0));
        out_ready_i = 1'b1;
        do_issue(3'd5, 4'd0, {4'd7, 4'd0, 4'd6}, 1'b0, {32'h700D, 32'h0, 32'h600D}, 1'b0, 5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
